spi_slave_rx: RTL and testbench

SPI slave receiver that consumes the SPI master's sck/mosi/cs outputs and reassembles bytes for the system-side consumer. sck, cs and mosi are treated as asynchronous and oversampled by the local clock. Received words are presented on a valid/ready handshake, with overrun and frame-abort flags. Optionally returns a MISO response word per frame.

---
 rtl/spi_pkg.sv | 16 +
 rtl/spi_sync_edge.sv | 69 ++++++
 rtl/spi_slave_rx.sv | 186 ++++++++++++++++++
 tb/tb_spi_slave_rx.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding, default word width and the
// bus idle/active levels that master and slave agree on.
package spi_pkg;

    localparam int DATA_W_DEF = 8;

    // Pin levels common to master and slave.
    localparam logic SCK_IDLE  = 1'b0;
    localparam logic CS_ACTIVE = 1'b1;

    typedef logic [0:0] state_t;

    localparam state_t ST_IDLE   = 1'b0;
    localparam state_t ST_ACTIVE = 1'b1;

endpackage

// File: rtl/spi_sync_edge.sv
// Input conditioning for the SPI slave: identical synchroniser chains for
// sck, cs and mosi so the three stay aligned, followed by one output register
// that produces sck rise/fall pulses together with the matching cs/mosi.
module spi_sync_edge
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sck,
    input  logic cs,
    input  logic mosi,
    output logic sck_rise,
    output logic sck_fall,
    output logic s_cs,
    output logic s_mosi
);

    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic sck_prev_q, sck_prev_d;
    logic sck_rise_q, sck_rise_d;
    logic sck_fall_q, sck_fall_d;
    logic s_cs_q, s_cs_d;
    logic s_mosi_q, s_mosi_d;

    // Shift the pins into the chains and detect sck edges on the last stage.
    always_comb begin
        sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], sck};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        sck_prev_d  = sck_sync_q[SYNC_STAGES-1];
        sck_rise_d  = sck_sync_q[SYNC_STAGES-1] & ~sck_prev_q;
        sck_fall_d  = ~sck_sync_q[SYNC_STAGES-1] & sck_prev_q;
        s_cs_d      = cs_sync_q[SYNC_STAGES-1];
        s_mosi_d    = mosi_sync_q[SYNC_STAGES-1];
    end

    // Synchroniser and edge-detector registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_sync_q  <= {SYNC_STAGES{SCK_IDLE}};
            cs_sync_q   <= '0;
            mosi_sync_q <= '0;
            sck_prev_q  <= SCK_IDLE;
            sck_rise_q  <= 1'b0;
            sck_fall_q  <= 1'b0;
            s_cs_q      <= 1'b0;
            s_mosi_q    <= 1'b0;
        end else begin
            sck_sync_q  <= sck_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sck_prev_q  <= sck_prev_d;
            sck_rise_q  <= sck_rise_d;
            sck_fall_q  <= sck_fall_d;
            s_cs_q      <= s_cs_d;
            s_mosi_q    <= s_mosi_d;
        end
    end

    assign sck_rise = sck_rise_q;
    assign sck_fall = sck_fall_q;
    assign s_cs     = s_cs_q;
    assign s_mosi   = s_mosi_q;

endmodule

// File: rtl/spi_slave_rx.sv
// SPI slave receiver (mode 0, MSB first). Oversamples sck/cs/mosi on clk,
// reassembles DATA_W-bit words and offers them on a valid/ready handshake
// with overrun and frame-abort pulses.
// Build option SPI_SLAVE_MISO_EN adds tx_data/miso and a response shifter.
//
// state  | meaning
// IDLE   | cs inactive, waiting for a frame
// ACTIVE | cs active, shifting bits on sck rising edges
module spi_slave_rx
    import spi_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sck,
    input  logic              cs,
    input  logic              mosi,
    input  logic              rx_ready,
`ifdef SPI_SLAVE_MISO_EN
    input  logic [DATA_W-1:0] tx_data,
    output logic              miso,
`endif
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              overrun,
    output logic              frame_err,
    output logic              busy
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    logic sck_rise, s_cs, s_mosi;
`ifdef SPI_SLAVE_MISO_EN
    logic sck_fall;
`else
    logic sck_fall_unused;
`endif

    spi_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
        .clk     (clk),
        .rst     (rst),
        .sck     (sck),
        .cs      (cs),
        .mosi    (mosi),
        .sck_rise(sck_rise),
`ifdef SPI_SLAVE_MISO_EN
        .sck_fall(sck_fall),
`else
        .sck_fall(sck_fall_unused),
`endif
        .s_cs    (s_cs),
        .s_mosi  (s_mosi)
    );

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              overrun_q, overrun_d;
    logic              frame_err_q, frame_err_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] word_next;
    logic              word_done;

    // Frame FSM, bit shifter and output handshake. A cs exit outranks a
    // simultaneous sck rise, so that last bit is dropped.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        overrun_d   = 1'b0;
        frame_err_d = 1'b0;
        busy_d      = s_cs;
        word_done   = 1'b0;
        word_next   = {shreg_q[DATA_W-2:0], s_mosi};

        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (s_cs == CS_ACTIVE) begin
                    state_d   = ST_ACTIVE;
                    bit_cnt_d = '0;
                    shreg_d   = '0;
                end
            end
            ST_ACTIVE: begin
                if (s_cs != CS_ACTIVE) begin
                    state_d     = ST_IDLE;
                    bit_cnt_d   = '0;
                    frame_err_d = (bit_cnt_q != '0);
                end else if (sck_rise) begin
                    shreg_d = word_next;
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        word_done = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A fresh word overrides a same-cycle acceptance; it only counts as
        // an overrun when the previous word was still pending and not taken.
        if (word_done) begin
            rx_data_d  = word_next;
            rx_valid_d = 1'b1;
            overrun_d  = rx_valid_q & ~rx_ready;
        end
    end

    // Receiver state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;

`ifdef SPI_SLAVE_MISO_EN
    logic [DATA_W-1:0] tx_shreg_q, tx_shreg_d;

    // Response shifter: load at frame start, shift on sck falls. The first
    // fall after a completed word (bit_cnt back at 0) reloads instead, so the
    // next word's MSB is on miso before the master's next rising edge.
    always_comb begin
        tx_shreg_d = tx_shreg_q;
        if (state_q == ST_IDLE) begin
            if (s_cs == CS_ACTIVE) begin
                tx_shreg_d = tx_data;
            end
        end else if ((s_cs == CS_ACTIVE) && sck_fall) begin
            if (bit_cnt_q == '0) begin
                tx_shreg_d = tx_data;
            end else begin
                tx_shreg_d = {tx_shreg_q[DATA_W-2:0], 1'b0};
            end
        end
    end

    // Response shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_shreg_q <= '0;
        end else begin
            tx_shreg_q <= tx_shreg_d;
        end
    end

    assign miso = (state_q == ST_ACTIVE) ? tx_shreg_q[DATA_W-1] : 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_rx.sv
// Bench for spi_slave_rx: directed frames plus randomized frames checked
// against a one-deep mailbox model of the receiver.
module tb_spi_slave_rx;

    localparam int W  = 8;
    localparam int SS = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sck = 1'b0;
    logic cs = 1'b0;
    logic mosi = 1'b0;
    logic rx_ready = 1'b1;
    logic [W-1:0] rx_data;
    logic rx_valid, overrun, frame_err, busy;
`ifdef SPI_SLAVE_MISO_EN
    logic [W-1:0] tx_data = '0;
    logic miso;
    logic miso_seen[$];
`endif

    always #5 clk = ~clk;

    spi_slave_rx #(.DATA_W(W), .SYNC_STAGES(SS)) dut (
        .clk      (clk),
        .rst      (rst),
        .sck      (sck),
        .cs       (cs),
        .mosi     (mosi),
        .rx_ready (rx_ready),
`ifdef SPI_SLAVE_MISO_EN
        .tx_data  (tx_data),
        .miso     (miso),
`endif
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .overrun  (overrun),
        .frame_err(frame_err),
        .busy     (busy)
    );

    int n_checks = 0;
    int n_err = 0;
    int n_ovr = 0;
    int n_ferr = 0;
    logic [W-1:0] got_q[$];

    // Record accepted words and flag pulses away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid && rx_ready) got_q.push_back(rx_data);
            if (overrun) n_ovr++;
            if (frame_err) n_ferr++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send_bit(input logic b);
        mosi = b;
        tick(4);
`ifdef SPI_SLAVE_MISO_EN
        miso_seen.push_back(miso);
`endif
        sck = 1'b1;
        tick(4);
        sck = 1'b0;
    endtask

    task automatic send_word(input logic [W-1:0] w, input int nbits);
        for (int i = 0; i < nbits; i++) send_bit(w[W-1-i]);
    endtask

    task automatic frame_begin();
        cs = 1'b1;
        tick(6);
    endtask

    task automatic frame_end();
        tick(4);
        cs = 1'b0;
        tick(8);
    endtask

    task automatic expect_word(input string tag, input logic [W-1:0] exp);
        logic [W-1:0] g;
        g = 'x;
        if (got_q.size() > 0) g = got_q.pop_front();
        chk(tag, {24'd0, g}, {24'd0, exp});
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rx_data"}, {24'd0, rx_data}, 32'd0);
        chk({tag, "_rx_valid"}, {31'd0, rx_valid}, 32'd0);
        chk({tag, "_overrun"}, {31'd0, overrun}, 32'd0);
        chk({tag, "_frame_err"}, {31'd0, frame_err}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int lat, ovr0, ferr0, nw;
        logic rdy;
        logic [W-1:0] words[3];

        // Reset state
        rst = 1'b1;
        tick(4);
        chk_all_zero("reset");
        rst = 1'b0;
        tick(4);

        // Single frame 0xA5, last bit timed for latency
        ovr0 = n_ovr;
        ferr0 = n_ferr;
        frame_begin();
        send_word(8'hA5, 7);
        mosi = 1'b1;
        tick(4);
        sck = 1'b1;
        lat = 0;
        while (!rx_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", lat, SS + 2);
        #1;
        tick(3);
        sck = 1'b0;
        frame_end();
        expect_word("single_a5", 8'hA5);
        chk("single_ovr", n_ovr - ovr0, 0);
        chk("single_ferr", n_ferr - ferr0, 0);

        // Back-to-back words in one frame
        frame_begin();
        send_word(8'h3C, 8);
        chk("b2b_busy1", {31'd0, busy}, 32'd1);
        send_word(8'hC3, 8);
        chk("b2b_busy2", {31'd0, busy}, 32'd1);
        frame_end();
        expect_word("b2b_w0", 8'h3C);
        expect_word("b2b_w1", 8'hC3);
        chk("b2b_idle_busy", {31'd0, busy}, 32'd0);

        // Overrun with consumer stalled
        ovr0 = n_ovr;
        rx_ready = 1'b0;
        frame_begin();
        send_word(8'h11, 8);
        send_word(8'h22, 8);
        frame_end();
        chk("ovr_data", {24'd0, rx_data}, 32'h22);
        chk("ovr_valid", {31'd0, rx_valid}, 32'd1);
        chk("ovr_pulses", n_ovr - ovr0, 1);
        chk("ovr_none_taken", got_q.size(), 0);
        rx_ready = 1'b1;
        tick(2);
        expect_word("ovr_accept", 8'h22);
        chk("ovr_cleared", {31'd0, rx_valid}, 32'd0);

        // Abort after 5 bits, then a full frame
        ferr0 = n_ferr;
        frame_begin();
        send_word(8'hFF, 5);
        frame_end();
        chk("abort_ferr", n_ferr - ferr0, 1);
        chk("abort_no_word", got_q.size(), 0);
        chk("abort_no_valid", {31'd0, rx_valid}, 32'd0);
        frame_begin();
        send_word(8'h0F, 8);
        frame_end();
        expect_word("after_abort", 8'h0F);
        chk("after_abort_data", {24'd0, rx_data}, 32'h0F);

        // Reset in the middle of a frame
        ferr0 = n_ferr;
        frame_begin();
        send_word(8'hE7, 3);
        rst = 1'b1;
        tick(1);
        chk_all_zero("midrst");
        rst = 1'b0;
        tick(2);
        cs = 1'b0;
        tick(10);
        chk("midrst_no_ferr", n_ferr - ferr0, 0);
        chk("midrst_no_word", got_q.size(), 0);
        frame_begin();
        send_word(8'h81, 8);
        frame_end();
        expect_word("after_rst", 8'h81);

        // Randomized frames against a one-deep mailbox model
        for (int f = 0; f < 6; f++) begin
            nw = int'($urandom_range(1, 3));
            rdy = 1'($urandom_range(0, 1));
            for (int k = 0; k < nw; k++) words[k] = W'($urandom);
            ovr0 = n_ovr;
            rx_ready = rdy;
            frame_begin();
            for (int k = 0; k < nw; k++) send_word(words[k], 8);
            frame_end();
            if (rdy) begin
                for (int k = 0; k < nw; k++) expect_word("rand_word", words[k]);
                chk("rand_ovr_ready", n_ovr - ovr0, 0);
            end else begin
                chk("rand_hold_valid", {31'd0, rx_valid}, 32'd1);
                chk("rand_hold_data", {24'd0, rx_data}, {24'd0, words[nw-1]});
                chk("rand_ovr_stall", n_ovr - ovr0, nw - 1);
                rx_ready = 1'b1;
                tick(2);
                expect_word("rand_last", words[nw-1]);
            end
            rx_ready = 1'b1;
        end

`ifdef SPI_SLAVE_MISO_EN
        // Response word on miso, sampled at each sck rise
        tx_data = 8'h5A;
        miso_seen.delete();
        frame_begin();
        send_word(8'h96, 8);
        frame_end();
        expect_word("miso_rx", 8'h96);
        chk("miso_count", miso_seen.size(), 8);
        for (int i = 0; i < 8 && i < miso_seen.size(); i++) begin
            logic [7:0] pat;
            pat = 8'h5A;
            chk("miso_bit", {31'd0, miso_seen[i]}, {31'd0, pat[7-i]});
        end
        chk("miso_idle", {31'd0, miso}, 32'd0);
`endif

        chk("no_extra_words", got_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
